dataram_arbiter: RTL and testbench

Single-cycle arbiter that shares the single-port DataRAM (64 x 32-bit words, asynchronous read, synchronous write) between the CPU MEM stage and an external load/debug port. It sits between the EX/MEM pipeline register outputs and the DataRAM instance. It gives the CPU priority, serves the external port in CPU-idle cycles, and returns registered read data to the external requester. A compile-time starvation guard can force an external slot by asserting a pipeline hold.

---
 rtl/dataram_arbiter.sv | 111 +++++++++++
 tb/tb_dataram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dataram_arbiter.sv
// dataram_arbiter: shares the single-port DataRAM between the CPU MEM stage
// and an external load/debug port. The CPU has priority; the external port is
// served in CPU-idle cycles and gets its read data back one cycle after grant.
// Optional starvation guard: define DATARAM_ARB_STARVE_GUARD_EN to let a
// waiting external request force a slot by holding the pipeline for one cycle.
module dataram_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    // CPU MEM stage
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    // external port
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    // DataRAM
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_spo
);

    logic              cpu_req;
    logic              force_slot;
    logic              owner_ext;
    logic              ext_rvalid_reg;
    logic [DATA_W-1:0] ext_rdata_reg;

    assign cpu_req = cpu_rd | cpu_wr;

`ifdef DATARAM_ARB_STARVE_GUARD_EN
    localparam int              CNT_W      = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;

    // A request that has waited WAIT_MAX cycles takes the RAM this cycle.
    assign force_slot = ext_req && (wait_cnt_reg == WAIT_MAX_C);

    // Count cycles an external request has been left waiting, saturating.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!ext_req || owner_ext) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_MAX_C) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    // Strict CPU priority: the external port never preempts the pipeline.
    assign force_slot = 1'b0;
`endif

    // Ownership and RAM port steering; hold only when a real CPU access loses.
    always_comb begin
        owner_ext = ext_req & (~cpu_req | force_slot);
        cpu_hold  = force_slot & cpu_req;
        ext_gnt   = owner_ext;
        if (owner_ext) begin
            ram_a  = ext_addr;
            ram_d  = ext_wdata;
            ram_we = ext_we;
        end else begin
            ram_a  = cpu_addr;
            ram_d  = cpu_wdata;
            ram_we = cpu_wr;
        end
    end

    // Load data is a straight pass-through; only meaningful when CPU owns.
    assign cpu_rdata = ram_spo;

    // Capture external read data at the end of the grant cycle; hold it after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_rvalid_reg <= 1'b0;
            ext_rdata_reg  <= '0;
        end else begin
            ext_rvalid_reg <= owner_ext & ~ext_we;
            if (owner_ext && !ext_we) begin
                ext_rdata_reg <= ram_spo;
            end
        end
    end

    assign ext_rvalid = ext_rvalid_reg;
    assign ext_rdata  = ext_rdata_reg;

endmodule

// File: tb/tb_dataram_arbiter.sv
// tb_dataram_arbiter: directed test of dataram_arbiter with a behavioural
// 64x32 DataRAM (asynchronous read, synchronous write). Follows the starvation
// guard build when DATARAM_ARB_STARVE_GUARD_EN is defined.
module tb_dataram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_hold;
    logic        ext_req, ext_we;
    logic [5:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [5:0]  ram_a;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_spo;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    dataram_arbiter #(.ADDR_W(6), .DATA_W(32), .WAIT_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DataRAM.
    assign ram_spo = mem[ram_a];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (where inputs are driven).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d);
        ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b0;
        set_cpu(0, 0, 6'd0, 32'h0);
        set_ext(0, 0, 6'd0, 32'h0);

        // ---- reset state ----
        @(negedge clk);
        check("rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
        check("rst_rdata", ext_rdata, 32'd0);
        check("rst_hold", {31'b0, cpu_hold}, 32'd0);
        check("rst_gnt", {31'b0, ext_gnt}, 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // ---- CPU store then load ----
        set_cpu(0, 1, 6'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("cpu_st_we", {31'b0, ram_we}, 32'd1);
        check("cpu_st_a", {26'b0, ram_a}, 32'd5);
        check("cpu_st_d", ram_d, 32'hDEADBEEF);
        check("cpu_st_gnt", {31'b0, ext_gnt}, 32'd0);
        next_cycle();
        set_cpu(1, 0, 6'd5, 32'h0);
        @(negedge clk);
        check("cpu_ld_data", cpu_rdata, 32'hDEADBEEF);
        check("cpu_ld_gnt", {31'b0, ext_gnt}, 32'd0);
        next_cycle();
        $display("txn cpu store/load addr 5 data %h", cpu_rdata);

        // ---- external read while CPU idle ----
        set_cpu(0, 0, 6'd0, 32'h0);
        set_ext(1, 0, 6'd5, 32'h0);
        @(negedge clk);
        check("ext_rd_gnt", {31'b0, ext_gnt}, 32'd1);
        check("ext_rd_a", {26'b0, ram_a}, 32'd5);
        check("ext_rd_we", {31'b0, ram_we}, 32'd0);
        next_cycle();
        set_ext(0, 0, 6'd0, 32'h0);
        check("ext_rd_rvalid", {31'b0, ext_rvalid}, 32'd1);
        check("ext_rd_rdata", ext_rdata, 32'hDEADBEEF);
        next_cycle();
        check("ext_rd_rvalid_pulse", {31'b0, ext_rvalid}, 32'd0);
        check("ext_rd_rdata_held", ext_rdata, 32'hDEADBEEF);
        $display("txn ext read addr 5 data %h", ext_rdata);

        // ---- back-to-back ext write 63 then read 63 ----
        set_ext(1, 1, 6'd63, 32'h1);
        @(negedge clk);
        check("b2b_wr_gnt", {31'b0, ext_gnt}, 32'd1);
        check("b2b_wr_we", {31'b0, ram_we}, 32'd1);
        next_cycle();
        check("b2b_wr_no_rvalid", {31'b0, ext_rvalid}, 32'd0);
        set_ext(1, 0, 6'd63, 32'h0);
        @(negedge clk);
        check("b2b_rd_gnt", {31'b0, ext_gnt}, 32'd1);
        next_cycle();
        set_ext(0, 0, 6'd0, 32'h0);
        check("b2b_rd_rvalid", {31'b0, ext_rvalid}, 32'd1);
        check("b2b_rd_rdata", ext_rdata, 32'h1);
        $display("txn ext write/read addr 63 data %h", ext_rdata);
        next_cycle();

        // ---- contention: CPU stores every cycle, ext read of 63 waiting ----
`ifdef DATARAM_ARB_STARVE_GUARD_EN
        set_ext(1, 0, 6'd63, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            set_cpu(0, 1, 6'd10, (k == 9) ? 32'h00000BAD : 32'h100 + k);
            @(negedge clk);
            check($sformatf("guard_gnt_c%0d", k), {31'b0, ext_gnt}, (k == 9) ? 32'd1 : 32'd0);
            check($sformatf("guard_hold_c%0d", k), {31'b0, cpu_hold}, (k == 9) ? 32'd1 : 32'd0);
            check($sformatf("guard_we_c%0d", k), {31'b0, ram_we}, (k == 9) ? 32'd0 : 32'd1);
            next_cycle();
        end
        set_ext(0, 0, 6'd0, 32'h0);
        set_cpu(1, 0, 6'd10, 32'h0);
        check("guard_rvalid", {31'b0, ext_rvalid}, 32'd1);
        check("guard_rdata", ext_rdata, 32'h1);
        @(negedge clk);
        check("guard_store_skipped", cpu_rdata, 32'h108);
        check("guard_hold_after", {31'b0, cpu_hold}, 32'd0);
        $display("txn guard forced ext read addr 63 data %h", ext_rdata);
        next_cycle();
`else
        set_ext(1, 0, 6'd63, 32'h0);
        for (int k = 1; k <= 100; k++) begin
            set_cpu(0, 1, 6'd10, 32'h100 + k);
            @(negedge clk);
            check($sformatf("strict_gnt_c%0d", k), {31'b0, ext_gnt}, 32'd0);
            check($sformatf("strict_hold_c%0d", k), {31'b0, cpu_hold}, 32'd0);
            next_cycle();
        end
        set_cpu(0, 0, 6'd0, 32'h0);
        @(negedge clk);
        check("strict_idle_gnt", {31'b0, ext_gnt}, 32'd1);
        check("strict_idle_a", {26'b0, ram_a}, 32'd63);
        next_cycle();
        set_ext(0, 0, 6'd0, 32'h0);
        set_cpu(1, 0, 6'd10, 32'h0);
        check("strict_rvalid", {31'b0, ext_rvalid}, 32'd1);
        check("strict_rdata", ext_rdata, 32'h1);
        @(negedge clk);
        check("strict_last_store", cpu_rdata, 32'h164);
        $display("txn strict-priority ext read addr 63 data %h", ext_rdata);
        next_cycle();
`endif

        // ---- reset one cycle after an ext read grant ----
        set_cpu(0, 0, 6'd0, 32'h0);
        set_ext(1, 0, 6'd5, 32'h0);
        @(negedge clk);
        check("rstmid_gnt", {31'b0, ext_gnt}, 32'd1);
        next_cycle();
        set_ext(0, 0, 6'd0, 32'h0);
        reset = 1'b0;
        #1;
        check("rstmid_rvalid", {31'b0, ext_rvalid}, 32'd0);
        check("rstmid_rdata", ext_rdata, 32'd0);
        check("rstmid_hold", {31'b0, cpu_hold}, 32'd0);
`ifdef DATARAM_ARB_STARVE_GUARD_EN
        check("rstmid_wait_cnt", 32'(dut.wait_cnt_reg), 32'd0);
`endif
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check($sformatf("rstmid_no_rvalid_%0d", k), {31'b0, ext_rvalid}, 32'd0);
        end
        $display("txn reset mid-read rvalid %0d rdata %h", ext_rvalid, ext_rdata);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
